dense_argmax: RTL and testbench

Classification stage directly downstream of the dense layer. Consumes the CLASS_COUNT signed scores streamed out of the dense output buffer, one per cycle, and tracks the running maximum and its index. Once all scores are in, it presents the winning class index (the predicted MNIST digit) with a held `done` flag. This is the last compute stage before the result register and the host interface.

---
 rtl/dense_argmax.sv | 118 +++++++++++
 tb/tb_dense_argmax.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dense_argmax.sv
// Running argmax over CLASS_COUNT signed scores streamed in one per cycle.
// Define DENSE_ARGMAX_SCORE_OUT_EN to expose the winning score on maxScore.
module dense_argmax #(
    parameter int CLASS_COUNT = 10,
    parameter int DATA_SIZE   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           dataValid,
    input  logic signed [DATA_SIZE-1:0]    dataIn,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CLASS_COUNT)-1:0] classIdx
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
    ,
    output logic signed [DATA_SIZE-1:0]    maxScore
`endif
);

    localparam int IDX_W = $clog2(CLASS_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            cnt_q;
    logic [IDX_W-1:0]            best_idx_q;
    logic signed [DATA_SIZE-1:0] best_val_q;
    logic [IDX_W-1:0]            class_idx_q;
    logic                        busy_q;
    logic                        done_q;

    logic                        accept;
    logic                        last_sample;
    logic                        take_new;
    logic [IDX_W-1:0]            best_idx_d;
    logic signed [DATA_SIZE-1:0] best_val_d;

    // Sample 0 always wins; later samples only on a strict greater-than, so ties keep the lower index.
    assign accept      = (state_q == COLLECT) && dataValid;
    assign last_sample = (cnt_q == LAST_IDX);
    assign take_new    = (cnt_q == '0) || (dataIn > best_val_q);
    assign best_val_d  = take_new ? dataIn : best_val_q;
    assign best_idx_d  = take_new ? cnt_q : best_idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            class_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A start here only transitions; a coincident dataValid is not a sample.
                    if (start) begin
                        state_q    <= COLLECT;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        cnt_q      <= '0;
                        best_idx_q <= '0;
                        best_val_q <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        best_idx_q <= best_idx_d;
                        best_val_q <= best_val_d;
                        if (last_sample) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cnt_q       <= '0;
                            class_idx_q <= best_idx_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign classIdx = class_idx_q;

`ifdef DENSE_ARGMAX_SCORE_OUT_EN
    logic signed [DATA_SIZE-1:0] max_score_q;

    // Held like classIdx: a new start leaves the previous result visible until the next finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_score_q <= '0;
        end else if (accept && last_sample) begin
            max_score_q <= best_val_d;
        end
    end

    assign maxScore = max_score_q;
`else
    // bestVal stays internal here; it still feeds the running compare.
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Directed testbench for dense_argmax; checks the maxScore port only when
// DENSE_ARGMAX_SCORE_OUT_EN is defined.
module tb_dense_argmax;

    localparam int CC = 10;
    localparam int DW = 16;
    localparam int IW = $clog2(CC);

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 dataValid;
    logic signed [DW-1:0] dataIn;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        classIdx;
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
    logic signed [DW-1:0] maxScore;
`endif

    int vectors;
    int miscompares;

    int basic_sc [CC] = '{3, -5, 12, 7, 0, 1, 2, -1, 4, 9};
    int neg_sc   [CC] = '{-8, -3, -3, -20, -3, -9, -7, -4, -5, -6};
    int last_sc  [CC] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 100};

    dense_argmax #(
        .CLASS_COUNT(CC),
        .DATA_SIZE  (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dataValid(dataValid),
        .dataIn   (dataIn),
        .busy     (busy),
        .done     (done),
        .classIdx (classIdx)
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
        ,
        .maxScore (maxScore)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_score(input string tag, input int exp);
`ifdef DENSE_ARGMAX_SCORE_OUT_EN
        check(tag, maxScore, exp);
`else
        if (exp == 0) begin end
`endif
    endtask

    // Pulses start, then streams sc[]; optional bubbles before each sample and
    // a second start alongside sample 4. Returns edges from start to done.
    task automatic run(input string name, input int sc [CC], input bit bub,
                       output int edges);
        edges     = 0;
        start     = 1'b1;
        dataValid = 1'b0;
        tick();
        start = 1'b0;
        edges++;
        check({name, "_busy_rise"}, busy, 1);
        check({name, "_done_drop"}, done, 0);
        for (int i = 0; i < CC; i++) begin
            if (bub) begin
                dataValid = 1'b0;
                dataIn    = 16'sh7fff;
                tick();
                edges++;
                check({name, "_bubble_busy"}, busy, 1);
            end
            dataValid = 1'b1;
            dataIn    = DW'(sc[i]);
            start     = bub && (i == 4);
            tick();
            edges++;
            start     = 1'b0;
            dataValid = 1'b0;
            if (i < CC - 1) begin
                check({name, "_done_early"}, done, 0);
            end
        end
        check({name, "_done"}, done, 1);
        check({name, "_busy_fall"}, busy, 0);
        $display("%s: edges=%0d classIdx=%0d done=%0b", name, edges, classIdx, done);
    endtask

    int edges;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        dataValid   = 1'b0;
        dataIn      = '0;

        // Reset, then idle with ignored dataValid pulses
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_idx", classIdx, 0);
        check_score("idle_score", 0);
        for (int i = 0; i < 3; i++) begin
            dataValid = 1'b1;
            dataIn    = 16'sd77;
            tick();
            dataValid = 1'b0;
            tick();
        end
        check("idle_dv_busy", busy, 0);
        check("idle_dv_done", done, 0);
        check("idle_dv_idx", classIdx, 0);
        check_score("idle_dv_score", 0);

        // Basic run
        run("basic", basic_sc, 1'b0, edges);
        check("basic_latency", edges, CC + 1);
        check("basic_idx", classIdx, 2);
        check_score("basic_score", 12);

        // dataValid in DONE is ignored and the result holds
        dataValid = 1'b1;
        dataIn    = 16'sd1000;
        tick(); tick();
        dataValid = 1'b0;
        check("done_hold", done, 1);
        check("done_hold_idx", classIdx, 2);
        check_score("done_hold_score", 12);

        // Negatives and ties
        run("neg_ties", neg_sc, 1'b0, edges);
        check("neg_idx", classIdx, 1);
        check_score("neg_score", -3);

        // Bubbles plus an ignored start mid-run
        run("bubbles", basic_sc, 1'b1, edges);
        check("bub_latency", edges, 2 * CC + 1);
        check("bub_idx", classIdx, 2);
        check_score("bub_score", 12);

        // From DONE: start with a coincident large sample that must be dropped
        start     = 1'b1;
        dataValid = 1'b1;
        dataIn    = 16'sd500;
        tick();
        start     = 1'b0;
        dataValid = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_busy", busy, 1);
        check("b2b_old_idx", classIdx, 2);
        check_score("b2b_old_score", 12);
        for (int i = 0; i < CC; i++) begin
            dataValid = 1'b1;
            dataIn    = DW'(last_sc[i]);
            tick();
        end
        dataValid = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_idx", classIdx, 9);
        check_score("b2b_score", 100);
        $display("back_to_back: classIdx=%0d done=%0b", classIdx, done);

        // Restart and reset after 5 samples
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dataValid = 1'b1;
            dataIn    = DW'(basic_sc[i]);
            tick();
        end
        dataValid = 1'b0;
        check("mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_idx", classIdx, 0);
        check_score("mrst_score", 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        // Full run after the aborted one starts cleanly
        run("after_rst", basic_sc, 1'b0, edges);
        check("after_rst_idx", classIdx, 2);
        check_score("after_rst_score", 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
